// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: synchronises NUM_CH async inputs, latches qualified edges
// per channel and offers them round-robin on a valid/ready event port.
module edge_event_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         sig_in,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [2*NUM_CH-1:0]       edge_sel,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic                      evt_rise,
    output logic [NUM_CH-1:0]         overrun,
    input  logic                      overrun_clr
);
    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e            state_q;
    logic [NUM_CH-1:0] s0_q, s1_q, s2_q;
    logic [1:0]        warm_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] prise_q, prise_d;
    logic [NUM_CH-1:0] ovr_q, ovr_d;
    logic [NUM_CH-1:0] rise, fall, qual, new_ov, req, gnt_oh;
    logic [CW-1:0]     last_q, win, ch_q;
    logic              valid_q, rise_q, win_found, grant;

    always_comb begin
        rise = s1_q & ~s2_q;
        fall = ~s1_q & s2_q;
        qual = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            qual[c] = ((rise[c] & edge_sel[2*c]) | (fall[c] & edge_sel[2*c+1]))
                      & ch_enable[c] & (warm_q == 2'd0);
        end
    end

    // Disabled channels are never granted, even in the cycle they are flushed
    always_comb begin
        req       = pend_q & ch_enable;
        win       = '0;
        win_found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!win_found && req[(int'(last_q) + i) % NUM_CH]) begin
                win_found = 1'b1;
                win       = CW'((int'(last_q) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        grant  = win_found & ((state_q == IDLE) | evt_ready);
        gnt_oh = '0;
        if (grant) gnt_oh[win] = 1'b1;
    end

    always_comb begin
        pend_d  = pend_q & ~gnt_oh;
        prise_d = prise_q;
        new_ov  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (qual[c]) begin
                pend_d[c]  = 1'b1;
                prise_d[c] = rise[c];
                new_ov[c]  = pend_q[c] & ~gnt_oh[c];
            end
            if (!ch_enable[c]) pend_d[c] = 1'b0;
        end
        ovr_d = (ovr_q & ~{NUM_CH{overrun_clr}}) | new_ov;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            warm_q  <= 2'd3;
            pend_q  <= '0;
            prise_q <= '0;
            ovr_q   <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
            ch_q    <= '0;
            rise_q  <= 1'b0;
            last_q  <= CW'(NUM_CH - 1);
        end else begin
            s0_q    <= sig_in;
            s1_q    <= s0_q;
            s2_q    <= s1_q;
            if (warm_q != 2'd0) warm_q <= warm_q - 2'd1;
            pend_q  <= pend_d;
            prise_q <= prise_d;
            ovr_q   <= ovr_d;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= OFFER;
                        valid_q <= 1'b1;
                        ch_q    <= win;
                        rise_q  <= prise_q[win];
                        last_q  <= win;
                    end
                end
                OFFER: begin
                    if (grant) begin
                        ch_q    <= win;
                        rise_q  <= prise_q[win];
                        last_q  <= win;
                    end else if (evt_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign evt_valid = valid_q;
    assign evt_ch    = ch_q;
    assign evt_rise  = rise_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: directed scenarios plus random
// traffic, checked against a per-cycle behavioural model.
module tb_edge_event_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sig_in = '0;
    logic [N-1:0] ch_enable = '1;
    logic [2*N-1:0] edge_sel = '0;
    logic         evt_ready = 1'b0;
    logic         overrun_clr = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic         evt_rise;
    logic [N-1:0] overrun;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NUM_CH(N)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .ch_enable(ch_enable),
        .edge_sel(edge_sel), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_ch(evt_ch), .evt_rise(evt_rise), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    typedef struct packed {
        logic [3:0] ch;
        logic       rise;
    } evt_t;
    evt_t sbq[$];

    // Reference state: last three samples per channel, pending flags/types,
    // sticky overrun, current offer and last granted channel.
    bit [N-1:0] h0, h1, h2, m_pend, m_ptype, m_ovr;
    int m_warm;
    bit m_off;
    int m_last;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] qe, ne;
        int g;
        bit can;
        evt_t e;
        if (reset) begin
            h0 = '0; h1 = '0; h2 = '0;
            m_pend = '0; m_ptype = '0; m_ovr = '0;
            m_warm = 3; m_off = 1'b0; m_last = N - 1;
            sbq.delete();
            return;
        end
        for (int c = 0; c < N; c++) begin
            bit r, f;
            r = h1[c] && !h2[c];
            f = !h1[c] && h2[c];
            qe[c] = ch_enable[c] && (m_warm == 0) &&
                    ((r && edge_sel[2*c]) || (f && edge_sel[2*c+1]));
        end
        can = !m_off || evt_ready;
        g = -1;
        if (can) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last + i) % N;
                if (g < 0 && m_pend[c] && ch_enable[c]) g = c;
            end
            if (g >= 0) begin
                m_off = 1'b1;
                m_last = g;
                e.ch = 4'(g);
                e.rise = m_ptype[g];
                sbq.push_back(e);
            end else begin
                m_off = 1'b0;
            end
        end
        ne = '0;
        for (int c = 0; c < N; c++) begin
            if (!ch_enable[c]) m_pend[c] = 1'b0;
            else if (qe[c]) begin
                if (m_pend[c] && c != g) ne[c] = 1'b1;
                m_pend[c] = 1'b1;
                m_ptype[c] = h1[c];
            end else if (c == g) m_pend[c] = 1'b0;
        end
        m_ovr = overrun_clr ? ne : (m_ovr | ne);
        if (m_warm > 0) m_warm--;
        h2 = h1; h1 = h0; h0 = sig_in;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (mon_on) begin
            chk("evt_valid", 32'(evt_valid), 32'(m_off));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (evt_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: DUT offers ch %0d, none expected", evt_ch);
                end else begin
                    chk("evt_ch", 32'(evt_ch), 32'(sbq[0].ch));
                    chk("evt_rise", 32'(evt_rise), 32'(sbq[0].rise));
                    if (evt_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        mon_on = 1'b1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        tick(5);

        // single rising edge latency on ch1
        edge_sel = 8'h04;
        sig_in[1] = 1'b1;
        tick(); chk("A_k", 32'(evt_valid), 0);
        tick(); chk("A_k1", 32'(evt_valid), 0);
        tick(); chk("A_k2", 32'(evt_valid), 0);
        tick();
        chk("A_valid", 32'(evt_valid), 1);
        chk("A_ch", 32'(evt_ch), 1);
        chk("A_rise", 32'(evt_rise), 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("A_done", 32'(evt_valid), 0);

        // all channels rise together, back-to-back grants
        reset = 1'b1; sig_in = '0; edge_sel = '0;
        tick(2);
        reset = 1'b0;
        tick(5);
        edge_sel = 8'h55;
        evt_ready = 1'b1;
        sig_in = 4'hF;
        tick(3);
        for (int i = 0; i < N; i++) begin
            tick();
            chk("B_valid", 32'(evt_valid), 1);
            chk("B_ch", 32'(evt_ch), 32'(i));
        end
        tick();
        chk("B_idle", 32'(evt_valid), 0);
        evt_ready = 1'b0;

        // overrun on ch2 while consumer stalls
        edge_sel = '0; sig_in = '0;
        tick(4);
        edge_sel = 8'h30;
        sig_in[2] = 1'b1; tick(3);
        sig_in[2] = 1'b0; tick(3);
        sig_in[2] = 1'b1; tick(3);
        sig_in[2] = 1'b0; tick(4);
        chk("C_ovr", 32'(overrun), 32'h4);
        chk("C_ch", 32'(evt_ch), 2);
        chk("C_rise1", 32'(evt_rise), 1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("C_valid2", 32'(evt_valid), 1);
        chk("C_rise2", 32'(evt_rise), 0);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        chk("C_clr", 32'(overrun), 0);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("C_idle", 32'(evt_valid), 0);

        // level already high across reset
        reset = 1'b1; sig_in = 4'b0001; edge_sel = 8'h01;
        tick(2);
        reset = 1'b0;
        repeat (10) begin
            tick();
            chk("D_no_evt", 32'(evt_valid), 0);
        end

        // flush of a pending channel by ch_enable
        edge_sel = 8'h44;
        sig_in[1] = 1'b1; tick(5);
        chk("E_ch1", 32'(evt_ch), 1);
        sig_in[3] = 1'b1; tick(3);
        ch_enable = 4'b0111; tick();
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("E_idle", 32'(evt_valid), 0);
        ch_enable = '1; tick(6);
        chk("E_flushed", 32'(evt_valid), 0);

        // reset during a stalled offer
        edge_sel = 8'h0C;
        sig_in[1] = 1'b0; tick(5);
        sig_in[1] = 1'b1; tick(3);
        sig_in[1] = 1'b0; tick(4);
        chk("F_ovr", 32'(overrun), 32'h2);
        chk("F_valid", 32'(evt_valid), 1);
        reset = 1'b1; tick();
        chk("F_rst_valid", 32'(evt_valid), 0);
        chk("F_rst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        tick(5);

        // random traffic
        edge_sel = 8'($urandom);
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(5) == 0) sig_in[c] = ~sig_in[c];
            evt_ready = ($urandom_range(2) != 0);
            overrun_clr = ($urandom_range(19) == 0);
            if ($urandom_range(63) == 0) edge_sel = 8'($urandom);
            if ($urandom_range(31) == 0)
                ch_enable = ($urandom_range(1) != 0) ? '1 : 4'($urandom);
            reset = ($urandom_range(399) == 0);
            tick();
        end

        reset = 1'b0; overrun_clr = 1'b0; ch_enable = '1; evt_ready = 1'b1;
        tick(20);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
